// File: rtl/adc_sample_formatter_if.sv
// Sample/result bundle between the ADC capture side and the sample formatter.
// The master drives samples and mode bits; the slave (formatter) returns the formatted word.
interface adc_sample_formatter_if #(
  parameter int IN_BITS  = 12,
  parameter int OUT_BITS = 13
);
  logic [IN_BITS-1:0]  din;
  logic                din_valid;
  logic                offset_mode;
  logic                round_en;
  logic [OUT_BITS-1:0] dout;
  logic                dout_valid;
  logic                overflow;

  modport master (
    output din, din_valid, offset_mode, round_en,
    input  dout, dout_valid, overflow
  );

  modport slave (
    input  din, din_valid, offset_mode, round_en,
    output dout, dout_valid, overflow
  );
endinterface

// File: rtl/adc_sample_formatter.sv
// ADC sample formatter: optional block average, top-bit select with round/saturate,
// then offset-binary or two's-complement extension for the servo PWM path.
module adc_sample_formatter #(
  parameter int IN_BITS  = 12,
  parameter int SEL_BITS = 8,
  parameter int OUT_BITS = 13,
  parameter int AVG_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  adc_sample_formatter_if.slave bus
);
  localparam int AW  = IN_BITS + AVG_LOG2;
  localparam int CW  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int SH  = IN_BITS - SEL_BITS;
  localparam int HSH = (SH > 0) ? SH - 1 : 0;
  localparam logic [CW-1:0]       CNT_LAST = CW'((1 << AVG_LOG2) - 1);
  localparam logic [IN_BITS:0]    HALF     = (SH > 0) ? ((IN_BITS+1)'(1) << HSH) : '0;
  localparam logic [SEL_BITS-1:0] MSB      = SEL_BITS'(1) << (SEL_BITS - 1);

  // Returns {overflow, field}; rounding only ever adds, so only the positive end saturates.
  function automatic logic [SEL_BITS:0] round_sat(input logic signed [IN_BITS-1:0] m,
                                                  input logic rnd);
    logic [IN_BITS:0] t;
    t = {m[IN_BITS-1], m} + HALF;
    if (rnd && (SH > 0)) begin
      if (!t[IN_BITS] && t[IN_BITS-1]) return {1'b1, ~MSB};
      return {1'b0, t[IN_BITS-1 -: SEL_BITS]};
    end
    return {1'b0, m[IN_BITS-1 -: SEL_BITS]};
  endfunction

  function automatic logic [OUT_BITS-1:0] extend(input logic [SEL_BITS-1:0] field,
                                                 input logic offs);
    if (offs) return OUT_BITS'(field ^ MSB);
    return OUT_BITS'($signed(field));
  endfunction

  logic signed [IN_BITS-1:0] r_din_p0;
  logic                      r_vld_p0, r_offs_p0, r_rnd_p0;
  logic signed [AW-1:0]      r_acc_p1;
  logic [CW-1:0]             r_cnt_p1;
  logic signed [IN_BITS-1:0] r_mean_p1;
  logic                      r_vld_p1, r_offs_p1, r_rnd_p1;
  logic [OUT_BITS-1:0]       r_dout_p2;
  logic                      r_vld_p2, r_ovf_p2;

  logic signed [AW-1:0]      w_sum;
  logic signed [AW-1:0]      w_shift;
  logic                      w_last;
  logic [SEL_BITS:0]         w_rs;

  assign w_sum   = r_acc_p1 + AW'(r_din_p0);
  assign w_shift = w_sum >>> AVG_LOG2;
  assign w_last  = (r_cnt_p1 == CNT_LAST);
  assign w_rs    = round_sat(r_mean_p1, r_rnd_p1);

  // ---- p0: input capture (sample and the mode bits that travel with it)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_din_p0  <= '0;
      r_vld_p0  <= 1'b0;
      r_offs_p0 <= 1'b0;
      r_rnd_p0  <= 1'b0;
    end else begin
      r_vld_p0 <= bus.din_valid;
      if (bus.din_valid) begin
        r_din_p0  <= $signed(bus.din);
        r_offs_p0 <= bus.offset_mode;
        r_rnd_p0  <= bus.round_en;
      end
    end
  end

  // ---- p1: block accumulate; modes latched only with the block's final sample
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc_p1  <= '0;
      r_cnt_p1  <= '0;
      r_mean_p1 <= '0;
      r_vld_p1  <= 1'b0;
      r_offs_p1 <= 1'b0;
      r_rnd_p1  <= 1'b0;
    end else begin
      r_vld_p1 <= 1'b0;
      if (r_vld_p0) begin
        if (w_last) begin
          r_mean_p1 <= IN_BITS'(w_shift);
          r_acc_p1  <= '0;
          r_cnt_p1  <= '0;
          r_vld_p1  <= 1'b1;
          r_offs_p1 <= r_offs_p0;
          r_rnd_p1  <= r_rnd_p0;
        end else begin
          r_acc_p1 <= w_sum;
          r_cnt_p1 <= r_cnt_p1 + CW'(1);
        end
      end
    end
  end

  // ---- p2: format; dout holds between strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dout_p2 <= '0;
      r_vld_p2  <= 1'b0;
      r_ovf_p2  <= 1'b0;
    end else begin
      r_vld_p2 <= r_vld_p1;
      r_ovf_p2 <= r_vld_p1 & w_rs[SEL_BITS];
      if (r_vld_p1) r_dout_p2 <= extend(w_rs[SEL_BITS-1:0], r_offs_p1);
    end
  end

  assign bus.dout       = r_dout_p2;
  assign bus.dout_valid = r_vld_p2;
  assign bus.overflow   = r_ovf_p2;
endmodule

// File: tb/tb_adc_sample_formatter.sv
// Bench for adc_sample_formatter: reference model from averaging/format rules,
// per-cycle compare process, directed literal cases and randomized traffic.
module tb_adc_sample_formatter;
  localparam int IN_BITS  = 12;
  localparam int SEL_BITS = 8;
  localparam int OUT_BITS = 13;
  localparam int AVG_LOG2 = 2;
  localparam int NAVG     = 1 << AVG_LOG2;
  localparam int SH       = IN_BITS - SEL_BITS;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  adc_sample_formatter_if #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_if ();

  adc_sample_formatter #(
    .IN_BITS(IN_BITS), .SEL_BITS(SEL_BITS), .OUT_BITS(OUT_BITS), .AVG_LOG2(AVG_LOG2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(u_if.slave)
  );

  typedef struct {
    int                  due;
    logic [OUT_BITS-1:0] d;
    bit                  ovf;
  } exp_t;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  exp_t q[$];
  logic [OUT_BITS-1:0] seen[$];
  int m_sum = 0;
  int m_cnt = 0;
  logic [OUT_BITS-1:0] exp_hold = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int floor_div(input int a, input int b);
    int r;
    r = a / b;
    if ((a % b != 0) && ((a < 0) != (b < 0))) r = r - 1;
    return r;
  endfunction

  // Mean of the block, keep value/2^SH (floor or round-half-up), clamp, then bias or wrap.
  function automatic void fmt(input int sum, input bit offs, input bit rnd,
                              output logic [OUT_BITS-1:0] d, output bit ovf);
    int mean, f;
    int fmax;
    mean = floor_div(sum, NAVG);
    fmax = (1 << (SEL_BITS - 1)) - 1;
    ovf  = 1'b0;
    if (rnd) f = floor_div(mean + (1 << (SH - 1)), 1 << SH);
    else     f = floor_div(mean, 1 << SH);
    if (f > fmax) begin
      f   = fmax;
      ovf = 1'b1;
    end
    if (offs) d = OUT_BITS'(f + (1 << (SEL_BITS - 1)));
    else      d = OUT_BITS'(f);
  endfunction

  // Reference model: sees exactly what the DUT accepts at each edge.
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    if (reset) begin
      q.delete();
      m_sum    = 0;
      m_cnt    = 0;
      exp_hold = '0;
    end else if (u_if.din_valid) begin
      m_sum += int'($signed(u_if.din));
      m_cnt++;
      if (m_cnt == NAVG) begin
        e.due = cyc + 2;
        fmt(m_sum, u_if.offset_mode, u_if.round_en, e.d, e.ovf);
        q.push_back(e);
        m_sum = 0;
        m_cnt = 0;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      check("strobe", 32'(u_if.dout_valid), 32'd1);
      check("dout", 32'(u_if.dout), 32'(e.d));
      check("overflow", 32'(u_if.overflow), 32'(e.ovf));
      exp_hold = e.d;
      seen.push_back(u_if.dout);
    end else begin
      check("idle_valid", 32'(u_if.dout_valid), 32'd0);
      check("idle_overflow", 32'(u_if.overflow), 32'd0);
      check("hold_dout", 32'(u_if.dout), 32'(exp_hold));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_block(input logic [IN_BITS-1:0] v0, v1, v2, v3,
                            input bit offs, input bit rnd, input int gap);
    logic [IN_BITS-1:0] v[4];
    v = '{v0, v1, v2, v3};
    for (int i = 0; i < 4; i++) begin
      u_if.din         = v[i];
      u_if.din_valid   = 1'b1;
      u_if.offset_mode = offs;
      u_if.round_en    = rnd;
      step();
      u_if.din_valid = 1'b0;
      if (i < 3) repeat (gap) step();
    end
  endtask

  // Called right after the final sample's accepting edge.
  task automatic expect_strobe(input string name, input logic [OUT_BITS-1:0] d, input bit ovf);
    int acc_cyc;
    bit got;
    acc_cyc = cyc;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (u_if.dout_valid) got = 1'b1;
    end
    check({name, "_seen"}, 32'(got), 32'd1);
    if (got) begin
      check({name, "_latency"}, 32'(cyc - acc_cyc), 32'd2);
      check({name, "_dout"}, 32'(u_if.dout), 32'(d));
      check({name, "_ovf"}, 32'(u_if.overflow), 32'(ovf));
    end
    step();
  endtask

  initial begin
    logic [OUT_BITS-1:0] pd;
    bit po;
    logic [OUT_BITS-1:0] ref_seq[$];
    logic [IN_BITS-1:0] rv[8];
    int strobes;

    u_if.din = '0;
    u_if.din_valid = 1'b0;
    u_if.offset_mode = 1'b0;
    u_if.round_en = 1'b0;

    // Pin the model with hand-computed values.
    fmt(4 * 2047, 1'b1, 1'b1, pd, po);
    check("model_sat", {19'd0, po, pd}, {19'd0, 1'b1, 13'h00FF});
    fmt(-5, 1'b0, 1'b0, pd, po);
    check("model_neg", {19'd0, po, pd}, {19'd0, 1'b0, 13'h1FFF});
    fmt(4 * 24, 1'b1, 1'b1, pd, po);
    check("model_round", {19'd0, po, pd}, {19'd0, 1'b0, 13'h0082});

    repeat (3) step();
    @(negedge clk);
    check("reset_dout", 32'(u_if.dout), 32'd0);
    check("reset_valid", 32'(u_if.dout_valid), 32'd0);
    check("reset_ovf", 32'(u_if.overflow), 32'd0);
    step();
    reset = 1'b0;
    step();

    send_block(12'h7FF, 12'h7FF, 12'h7FF, 12'h7FF, 1'b1, 1'b0, 0);
    expect_strobe("max_offs", 13'h00FF, 1'b0);
    send_block(12'h7FF, 12'h7FF, 12'h7FF, 12'h7FF, 1'b1, 1'b1, 0);
    expect_strobe("max_offs_rnd", 13'h00FF, 1'b1);
    send_block(12'h7FF, 12'h7FF, 12'h7FF, 12'h7FF, 1'b0, 1'b1, 0);
    expect_strobe("max_tc_rnd", 13'h007F, 1'b1);
    send_block(12'h018, 12'h018, 12'h018, 12'h018, 1'b0, 1'b0, 0);
    expect_strobe("x18_tc", 13'h0001, 1'b0);
    send_block(12'h018, 12'h018, 12'h018, 12'h018, 1'b0, 1'b1, 0);
    expect_strobe("x18_tc_rnd", 13'h0002, 1'b0);
    send_block(12'h018, 12'h018, 12'h018, 12'h018, 1'b1, 1'b0, 0);
    expect_strobe("x18_offs", 13'h0081, 1'b0);
    send_block(12'h018, 12'h018, 12'h018, 12'h018, 1'b1, 1'b1, 0);
    expect_strobe("x18_offs_rnd", 13'h0082, 1'b0);
    send_block(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFE, 1'b0, 1'b0, 0);
    expect_strobe("neg_tc", 13'h1FFF, 1'b0);
    send_block(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFE, 1'b1, 1'b0, 0);
    expect_strobe("neg_offs", 13'h007F, 1'b0);
    send_block(12'h800, 12'h800, 12'h800, 12'h800, 1'b1, 1'b0, 0);
    expect_strobe("min_offs", 13'h0000, 1'b0);

    // Back-to-back versus valid-every-3rd-cycle must yield the same results.
    for (int i = 0; i < 8; i++) rv[i] = IN_BITS'($urandom);
    seen.delete();
    send_block(rv[0], rv[1], rv[2], rv[3], 1'b0, 1'b1, 0);
    send_block(rv[4], rv[5], rv[6], rv[7], 1'b1, 1'b1, 0);
    repeat (4) step();
    ref_seq = seen;
    seen.delete();
    send_block(rv[0], rv[1], rv[2], rv[3], 1'b0, 1'b1, 2);
    send_block(rv[4], rv[5], rv[6], rv[7], 1'b1, 1'b1, 2);
    repeat (4) step();
    check("gap_count", 32'(seen.size()), 32'(ref_seq.size()));
    for (int i = 0; i < ref_seq.size() && i < seen.size(); i++)
      check("gap_seq", 32'(seen[i]), 32'(ref_seq[i]));

    // 12 back-to-back samples -> 3 single-cycle strobes.
    seen.delete();
    strobes = 0;
    for (int i = 0; i < 12; i++) begin
      u_if.din = IN_BITS'($urandom);
      u_if.din_valid = 1'b1;
      step();
      if (u_if.dout_valid) strobes++;
    end
    u_if.din_valid = 1'b0;
    repeat (4) begin
      step();
      if (u_if.dout_valid) strobes++;
    end
    check("b2b_strobes", 32'(strobes), 32'd3);

    // Reset mid-block discards the partial block.
    u_if.offset_mode = 1'b0;
    u_if.round_en = 1'b0;
    repeat (2) begin
      u_if.din = 12'h7FF;
      u_if.din_valid = 1'b1;
      step();
    end
    u_if.din_valid = 1'b0;
    reset = 1'b1;
    step();
    @(negedge clk);
    check("midrst_dout", 32'(u_if.dout), 32'd0);
    check("midrst_valid", 32'(u_if.dout_valid), 32'd0);
    step();
    reset = 1'b0;
    send_block(12'h018, 12'h018, 12'h018, 12'h018, 1'b0, 1'b0, 0);
    expect_strobe("after_rst", 13'h0001, 1'b0);

    // Reset while a result is in flight drops the strobe.
    send_block(12'h300, 12'h300, 12'h300, 12'h300, 1'b0, 1'b0, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    strobes = 0;
    repeat (5) begin
      @(negedge clk);
      if (u_if.dout_valid) strobes++;
    end
    check("pending_rst_nostrobe", 32'(strobes), 32'd0);
    step();

    // Randomized traffic with extremes, mode flips and occasional reset.
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 5))
        0:       u_if.din = 12'h7FF;
        1:       u_if.din = 12'h800;
        2:       u_if.din = 12'h7F8;
        default: u_if.din = IN_BITS'($urandom);
      endcase
      u_if.din_valid   = ($urandom_range(0, 3) != 0);
      u_if.offset_mode = 1'($urandom);
      u_if.round_en    = 1'($urandom);
      reset            = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0;
    u_if.din_valid = 1'b0;
    repeat (6) step();
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
